// File: rtl/npc_pkg.sv
// Shared definitions for the instruction fetch unit.
//   RESET_PC_DEFAULT : first fetch address after reset unless overridden
//   fetch_state_e    : fetch FSM state encoding
//   INST_NOP         : canonical no-op encoding (addi x0, x0, 0)
package npc_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_EXEC = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/ifu_npc_sel.sv
// Next-pc selection (combinational).
// Ports:
//   i_pc                        current fetch pc
//   i_ecall_taken/i_ecall_target  highest-priority redirect
//   i_mret_taken/i_mret_target    second priority
//   i_branch_taken/i_branch_target third priority
//   o_npc                       selected next pc (pc+4 when no redirect, wraps mod 2^32)
// Targets pass through untouched; misalignment is handled by the fetch FSM.
module ifu_npc_sel (
   input  logic [31:0] i_pc,
   input  logic        i_ecall_taken,
   input  logic [31:0] i_ecall_target,
   input  logic        i_mret_taken,
   input  logic [31:0] i_mret_target,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_target,
   output logic [31:0] o_npc
);

   always_comb begin
      o_npc = i_pc + 32'd4;
      if (i_ecall_taken)
         o_npc = i_ecall_target;
      else if (i_mret_taken)
         o_npc = i_mret_target;
      else if (i_branch_taken)
         o_npc = i_branch_target;
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding fetch FSM, pc register and
// registered instruction handoff to the decode unit.
// Ports:
//   clk, rst (sync, active-low)
//   wb_done, *_taken, *_target   retire strobe and redirect requests from EXU
//   imem_req_*                   fetch request channel (valid/ready/addr)
//   imem_rsp_*                   fetch response channel (valid/data/err)
//   inst_valid/inst_ready, inst, inst_pc, fetch_err   handoff to IDU
//   perf_fetch_cnt               instructions accepted by IDU (wraps)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_REQ  | drive request for pc; misaligned pc loads an error instead
// ST_WAIT | request accepted, waiting for the single response
// ST_HOLD | instruction presented to IDU, held until accepted
// ST_EXEC | IDU owns the instruction; wait for retire to pick next pc
module ifu_fetch
   import npc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_done,
   input  logic        ecall_taken,
   input  logic        mret_taken,
   input  logic        branch_taken,
   input  logic [31:0] ecall_target,
   input  logic [31:0] mret_target,
   input  logic [31:0] branch_target,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        fetch_err,
   output logic [31:0] perf_fetch_cnt
);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   logic [31:0]  r_pc;
   logic [31:0]  r_inst;
   logic [31:0]  r_inst_pc;
   logic         r_fetch_err;
   logic [31:0]  r_perf_cnt;
   logic [31:0]  w_npc;
   logic         w_misalign;

   assign w_misalign = (r_pc[1:0] != 2'b00);

   ifu_npc_sel u_npc_sel (
      .i_pc            (r_pc),
      .i_ecall_taken   (ecall_taken),
      .i_ecall_target  (ecall_target),
      .i_mret_taken    (mret_taken),
      .i_mret_target   (mret_target),
      .i_branch_taken  (branch_taken),
      .i_branch_target (branch_target),
      .o_npc           (w_npc)
   );

   always_ff @(posedge clk) begin
      if (!rst)
         r_state <= ST_REQ;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      imem_req_valid = 1'b0;
      inst_valid     = 1'b0;
      case (r_state)
         ST_REQ: begin
            // A misaligned pc never reaches memory; the error goes straight to IDU.
            imem_req_valid = !w_misalign;
            if (w_misalign)
               w_state_nxt = ST_HOLD;
            else if (imem_req_ready)
               w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (imem_rsp_valid)
               w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            inst_valid = 1'b1;
            if (inst_ready)
               w_state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            if (wb_done)
               w_state_nxt = ST_REQ;
         end
         default: w_state_nxt = ST_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pc        <= RESET_PC;
         r_inst      <= 32'h0;
         r_inst_pc   <= 32'h0;
         r_fetch_err <= 1'b0;
         r_perf_cnt  <= 32'h0;
      end else begin
         case (r_state)
            ST_REQ: begin
               if (w_misalign) begin
                  r_inst      <= 32'h0;
                  r_fetch_err <= 1'b1;
                  r_inst_pc   <= r_pc;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  r_inst      <= imem_rsp_data;
                  r_fetch_err <= imem_rsp_err;
                  r_inst_pc   <= r_pc;
               end
            end
            ST_HOLD: begin
               if (inst_ready)
                  r_perf_cnt <= r_perf_cnt + 32'd1;
            end
            ST_EXEC: begin
               if (wb_done)
                  r_pc <= w_npc;
            end
            default: ;
         endcase
      end
   end

   assign imem_req_addr  = r_pc;
   assign inst           = r_inst;
   assign inst_pc        = r_inst_pc;
   assign fetch_err      = r_fetch_err;
   assign perf_fetch_cnt = r_perf_cnt;

endmodule
